// File: rtl/color_pkg.sv
// Shared filter mode encoding and luma weights for the colour filter pipeline.
package color_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_GRAY = 2'b01,
        MODE_INV  = 2'b10,
        MODE_THR  = 2'b11
    } mode_t;

    localparam int unsigned W_R     = 77;
    localparam int unsigned W_G     = 150;
    localparam int unsigned W_B     = 29;
    localparam int unsigned Y_SHIFT = 8;

endpackage

// File: rtl/luma_calc.sv
// Luma: registered per-channel weighted products, combinational sum and shift.
module luma_calc
    import color_pkg::*;
#(
    parameter int unsigned CH_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [CH_W-1:0] r_i,
    input  logic [CH_W-1:0] g_i,
    input  logic [CH_W-1:0] b_i,
    output logic [CH_W-1:0] luma_c_o
);

    localparam int unsigned PROD_W = CH_W + 8;
    localparam int unsigned SUM_W  = CH_W + 10;

    logic [PROD_W-1:0] prod_r_q, prod_g_q, prod_b_q;
    logic [SUM_W-1:0]  sum_c;

    // Products advance together with the S1 pixel register.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
        end else if (en_i) begin
            prod_r_q <= PROD_W'(r_i) * PROD_W'(W_R);
            prod_g_q <= PROD_W'(g_i) * PROD_W'(W_G);
            prod_b_q <= PROD_W'(b_i) * PROD_W'(W_B);
        end
    end

    always_comb begin
        sum_c    = SUM_W'(prod_r_q) + SUM_W'(prod_g_q) + SUM_W'(prod_b_q);
        luma_c_o = CH_W'(sum_c >> Y_SHIFT);
    end

endmodule

// File: rtl/color_filter_pipe.sv
// Two-stage valid/ready pixel filter: pass, gray, invert or threshold per pixel.
module color_filter_pipe
    import color_pkg::*;
#(
    parameter  int unsigned CH_W  = 8,
    localparam int unsigned PIX_W = 3 * CH_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [CH_W-1:0]  thresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic [15:0]      pix_count
);

    logic             en_c;
    logic             s1_valid_q;
    logic [PIX_W-1:0] s1_pix_q;
    mode_t            s1_mode_q;
    logic [CH_W-1:0]  s1_thresh_q;
    logic [CH_W-1:0]  luma_c;
    logic [PIX_W-1:0] result_c;
    logic             out_valid_q;
    logic [PIX_W-1:0] out_data_q;
    logic [15:0]      pix_count_q;

    // Whole pipe moves only when the output register is free or draining.
    assign en_c      = !out_valid_q || out_ready;
    assign in_ready  = en_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign pix_count = pix_count_q;

    luma_calc #(.CH_W(CH_W)) u_luma (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_c),
        .r_i      (in_data[PIX_W-1 -: CH_W]),
        .g_i      (in_data[CH_W +: CH_W]),
        .b_i      (in_data[CH_W-1:0]),
        .luma_c_o (luma_c)
    );

    // S1: pixel plus the mode and threshold in force when it was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_pix_q    <= '0;
            s1_mode_q   <= MODE_PASS;
            s1_thresh_q <= '0;
        end else if (en_c) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_pix_q    <= in_data;
                s1_mode_q   <= mode_t'(mode);
                s1_thresh_q <= thresh;
            end
        end
    end

    always_comb begin
        result_c = s1_pix_q;
        unique case (s1_mode_q)
            MODE_PASS: result_c = s1_pix_q;
            MODE_GRAY: result_c = {luma_c, luma_c, luma_c};
            MODE_INV:  result_c = ~s1_pix_q;
            MODE_THR:  result_c = (luma_c >= s1_thresh_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            default:   result_c = s1_pix_q;
        endcase
    end

    // S2: output register, held stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en_c) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= result_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_count_q <= '0;
        end else if (out_valid_q && out_ready) begin
            pix_count_q <= pix_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_color_filter_pipe.sv
// Directed self-checking bench for color_filter_pipe (CH_W = 8).
module tb_color_filter_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  thresh;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [15:0] pix_count;

    int errors = 0;
    int checks = 0;

    color_filter_pipe #(.CH_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 2'b00;
        thresh    = 8'h00;
        in_data   = 24'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 24'h0) begin errors++; $display("FAIL reset_out_data: got %h want 000000", out_data); end
        checks++;
        if (pix_count !== 16'h0) begin errors++; $display("FAIL reset_pix_count: got %0d want 0", pix_count); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_gray();
        do_reset();
        mode     = 2'b01;
        in_data  = 24'hFF8000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL gray_early: out_valid got %b want 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL gray_valid: got %b want 1", out_valid); end
        checks++;
        if (out_data !== 24'h979797) begin errors++; $display("FAIL gray_data: got %h want 979797", out_data); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL gray_drain: out_valid got %b want 0", out_valid); end
        checks++;
        if (pix_count !== 16'd1) begin errors++; $display("FAIL gray_count: got %0d want 1", pix_count); end
    endtask

    task automatic test_invert_pass();
        do_reset();
        in_valid = 1'b1;
        in_data  = 24'h123456;
        mode     = 2'b10;
        tick();
        mode = 2'b00;
        tick();
        in_valid = 1'b0;
        mode     = 2'b10;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'hEDCBA9) begin
            errors++; $display("FAIL invert: got v=%b %h want v=1 EDCBA9", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'h123456) begin
            errors++; $display("FAIL pass: got v=%b %h want v=1 123456", out_valid, out_data);
        end
        tick();
        checks++;
        if (pix_count !== 16'd2) begin errors++; $display("FAIL invpass_count: got %0d want 2", pix_count); end
    endtask

    task automatic test_threshold();
        do_reset();
        in_valid = 1'b1;
        mode     = 2'b11;
        thresh   = 8'h80;
        in_data  = 24'h808080;
        tick();
        in_data = 24'h7F7F7F;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'hFFFFFF) begin
            errors++; $display("FAIL thr_equal: got v=%b %h want v=1 FFFFFF", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'h000000) begin
            errors++; $display("FAIL thr_below: got v=%b %h want v=1 000000", out_valid, out_data);
        end
    endtask

    task automatic test_mode_switch();
        // Pixel 0x123456 has Y = 11680 >> 8 = 0x2D.
        logic [1:0]  modes [4];
        logic [7:0]  thrs  [4];
        logic [23:0] exps  [4];
        modes = '{2'b01, 2'b10, 2'b11, 2'b00};
        thrs  = '{8'hFF, 8'h00, 8'h2D, 8'hFF};
        exps  = '{24'h2D2D2D, 24'hEDCBA9, 24'hFFFFFF, 24'h123456};
        do_reset();
        in_data = 24'h123456;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                in_valid = 1'b1;
                mode     = modes[k];
                thresh   = thrs[k];
            end else begin
                in_valid = 1'b0;
                mode     = 2'b10;
                thresh   = 8'hFF;
            end
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exps[k-2]) begin
                    errors++;
                    $display("FAIL mode_switch_%0d: got v=%b %h want v=1 %h", k - 2, out_valid, out_data, exps[k-2]);
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          sent      = 1;
        int          rcvd      = 0;
        bit          prev_stall = 1'b0;
        bit          saw_drop  = 1'b0;
        logic [23:0] prev_data = 24'h0;
        do_reset();
        mode = 2'b00;
        for (int c = 1; c <= 40 && rcvd < 5; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent <= 5);
            in_data   = 24'(sent);
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold_c%0d: got v=%b %h want v=1 %h", c, out_valid, out_data, prev_data);
                end
            end
            if (!in_ready) saw_drop = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                rcvd++;
                checks++;
                if (out_data !== 24'(rcvd)) begin
                    errors++; $display("FAIL order_%0d: got %h want %h", rcvd, out_data, 24'(rcvd));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcvd != 5) begin errors++; $display("FAIL bp_received: got %0d want 5 (timeout)", rcvd); end
        checks++;
        if (sent != 6) begin errors++; $display("FAIL bp_accepted: got %0d want 5", sent - 1); end
        checks++;
        if (!saw_drop) begin errors++; $display("FAIL bp_in_ready_drop: got never-low want low during stall"); end
        checks++;
        if (pix_count !== 16'd5) begin errors++; $display("FAIL bp_count: got %0d want 5", pix_count); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        mode      = 2'b00;
        in_valid  = 1'b1;
        in_data   = 24'hAAAAAA;
        tick();
        in_data = 24'hBBBBBB;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_loaded: out_valid got %b want 1", out_valid); end
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        checks++;
        if (pix_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", pix_count); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || pix_count !== 16'd0) begin
                errors++;
                $display("FAIL midrst_ghost_%0d: got v=%b cnt=%0d data=%h want v=0 cnt=0", k, out_valid, pix_count, out_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_gray();
        test_invert_pass();
        test_threshold();
        test_mode_switch();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
